abacus_window_ctrl: RTL
=======================

ABACUS_WINDOW_CTRL -- requirements
Module: abacus_window_ctrl

Interface
REQ-001 Parameter CNT_W, default 32: width of the window register and the elapsed counter.
REQ-002 aclk  input  1  clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 cfg_we  input  1  register write strobe, one cycle per write.
REQ-005 cfg_addr  input  1  register select: 0 = CTRL, 1 = WINDOW.
REQ-006 cfg_wdata  input  32  write data.
REQ-007 trigger  input  1  external start event (e.g. instruction issued); present only with ABACUS_WINDOW_TRIGGER_EN.
REQ-008 prof_enable  output  1  enable to the instruction and cache profilers.
REQ-009 prof_clear  output  1  one-cycle counter-clear pulse to the profilers.
REQ-010 elapsed  output  CNT_W  enabled cycles counted in the current or last window.
REQ-011 state_o  output  3  encoded state: IDLE=0, CLEAR=1, ARMED=2, RUN=3, DONE=4.
REQ-012 done_irq  output  1  window-complete interrupt, a level until acknowledged.
REQ-013 overrun  output  1  sticky flag: a window completed while done_irq was already set.

Function
REQ-014 CTRL bits are command pulses, not stored:
- [0] arm
- [1] trig_sel, latched on arm
- [2] auto_rearm, latched on arm
- [3] abort
- [4] irq_ack, which clears done_irq and overrun.
REQ-015 WINDOW writes SHALL take effect only in IDLE; writes in other states are dropped.
REQ-016 Arm in IDLE SHALL move to CLEAR next cycle; arm in other states is ignored.
REQ-017 CLEAR:
- prof_clear = 1 for exactly that cycle
- elapsed <= 0
- next state ARMED.
REQ-018 ARMED, trig_sel = 0: go to RUN next cycle.
REQ-019 ARMED, trig_sel = 1: stay until trigger = 1 is sampled, then go to RUN next cycle.
REQ-020 RUN: prof_enable = 1 and elapsed increments by 1 every cycle.
REQ-021 RUN, WINDOW = N > 0: move to DONE on the cycle elapsed reaches N, so prof_enable is high for exactly N cycles.
REQ-022 RUN, WINDOW = 0: run unbounded until abort; elapsed saturates at all-ones and does not wrap.
REQ-023 DONE lasts one cycle:
- prof_enable = 0
- done_irq is set on DONE entry
- elapsed is held.
REQ-024 DONE exit: go to CLEAR if auto_rearm is latched, otherwise to IDLE.
REQ-025 Abort in CLEAR, ARMED or RUN SHALL go to IDLE next cycle, with no done_irq and elapsed held.
REQ-026 Abort and arm written together: abort wins.
REQ-027 irq_ack on the same cycle as a done_irq set: the set wins.
REQ-028 DONE entry while done_irq = 1 SHALL set overrun.
REQ-029 prof_enable SHALL be 0 in every state except RUN.

Reset
REQ-030 Reset SHALL force:
- state IDLE
- WINDOW = 0
- latched trig_sel and auto_rearm = 0
- elapsed = 0
- prof_enable, prof_clear, done_irq and overrun = 0.
REQ-031 Reset asserted mid-RUN SHALL drop prof_enable asynchronously, with no done_irq.

Configuration
REQ-032 Macro ABACUS_WINDOW_TRIGGER_EN defined: the trigger port exists and trig_sel behaves as in REQ-018/019.
REQ-033 Macro undefined: the trigger port is absent, CTRL[1] is ignored, and ARMED always goes to RUN next cycle.

Verification
REQ-034 Bench SHALL cover these scenarios:
- WINDOW = 5, arm, trig_sel = 0: prof_clear for 1 cycle; prof_enable high exactly 5 cycles; elapsed = 5; done_irq = 1.
- WINDOW = 3, arm with trig_sel = 1, trigger held 0 for 10 cycles then pulsed: state_o = 2 during the wait; enable for exactly 3 cycles after the trigger.
- WINDOW = 0, run 20 cycles, abort: elapsed = 20; back in IDLE; done_irq = 0.
- WINDOW = 2, auto_rearm, no irq_ack: second DONE sets overrun = 1; irq_ack then clears both flags.
- Write WINDOW = 9 during RUN of a window of 4: the window still ends after 4 cycles; WINDOW reads back as 4.
- Assert rst for 1 cycle mid-RUN: all outputs 0 immediately; state_o = 0.

Source files
------------

// File: rtl/abacus_window_ctrl.sv
// Profiling-window sequencer: arms, clears and enables the profilers for a programmed cycle count.
// Optional external start trigger is compiled in with ABACUS_WINDOW_TRIGGER_EN.
//
// state | meaning
// IDLE  | waiting for arm; WINDOW writable
// CLEAR | one-cycle profiler clear, elapsed zeroed
// ARMED | waiting for start (trigger or immediate)
// RUN   | profilers enabled, elapsed counting
// DONE  | window complete, done_irq raised
module abacus_window_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             aclk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic             cfg_addr,
  input  logic [31:0]      cfg_wdata,
`ifdef ABACUS_WINDOW_TRIGGER_EN
  input  logic             trigger,
`endif
  output logic             prof_enable,
  output logic             prof_clear,
  output logic [CNT_W-1:0] elapsed,
  output logic [2:0]       state_o,
  output logic             done_irq,
  output logic             overrun
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_ARMED = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] window_q, window_d;
  logic [CNT_W-1:0] elapsed_q, elapsed_d, elapsed_inc;
  logic             auto_rearm_q, auto_rearm_d;
  logic             done_irq_q, done_irq_d;
  logic             overrun_q, overrun_d;
  logic             cmd, arm, abort, ack, done_set, start_ok;

`ifdef ABACUS_WINDOW_TRIGGER_EN
  logic trig_sel_q, trig_sel_d;
  assign start_ok = !trig_sel_q || trigger;
`else
  assign start_ok = 1'b1;
`endif

  assign cmd   = cfg_we && !cfg_addr;
  assign arm   = cmd && cfg_wdata[0];
  assign abort = cmd && cfg_wdata[3];
  assign ack   = cmd && cfg_wdata[4];

  // Saturating increment so an unbounded window never wraps.
  assign elapsed_inc = (&elapsed_q) ? elapsed_q : elapsed_q + CNT_W'(1);

  always_comb begin
    state_d      = state_q;
    window_d     = window_q;
    elapsed_d    = elapsed_q;
    auto_rearm_d = auto_rearm_q;
`ifdef ABACUS_WINDOW_TRIGGER_EN
    trig_sel_d   = trig_sel_q;
`endif
    if (cfg_we && cfg_addr && state_q == ST_IDLE)
      window_d = CNT_W'(cfg_wdata);
    case (state_q)
      ST_IDLE: begin
        if (arm && !abort) begin
          state_d      = ST_CLEAR;
          auto_rearm_d = cfg_wdata[2];
`ifdef ABACUS_WINDOW_TRIGGER_EN
          trig_sel_d   = cfg_wdata[1];
`endif
        end
      end
      ST_CLEAR: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          elapsed_d = '0;
          state_d   = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (abort)         state_d = ST_IDLE;
        else if (start_ok) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          elapsed_d = elapsed_inc;
          if (window_q != '0 && elapsed_inc == window_q)
            state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = auto_rearm_q ? ST_CLEAR : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // A completion in the same cycle as an acknowledge keeps the flags set.
  assign done_set = (state_q == ST_RUN) && (state_d == ST_DONE);

  always_comb begin
    done_irq_d = done_irq_q;
    overrun_d  = overrun_q;
    if (ack) begin
      done_irq_d = 1'b0;
      overrun_d  = 1'b0;
    end
    if (done_set) begin
      done_irq_d = 1'b1;
      if (done_irq_q) overrun_d = 1'b1;
    end
  end

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      window_q     <= '0;
      elapsed_q    <= '0;
      auto_rearm_q <= 1'b0;
      done_irq_q   <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      window_q     <= window_d;
      elapsed_q    <= elapsed_d;
      auto_rearm_q <= auto_rearm_d;
      done_irq_q   <= done_irq_d;
      overrun_q    <= overrun_d;
    end
  end

`ifdef ABACUS_WINDOW_TRIGGER_EN
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) trig_sel_q <= 1'b0;
    else     trig_sel_q <= trig_sel_d;
  end
`endif

  assign prof_enable = (state_q == ST_RUN);
  assign prof_clear  = (state_q == ST_CLEAR);
  assign elapsed     = elapsed_q;
  assign state_o     = state_q;
  assign done_irq    = done_irq_q;
  assign overrun     = overrun_q;

endmodule
